// File: rtl/demo_sequencer.sv
// Frame-level demo scheduler: part index, frame-in-part, fade level and beat
// envelope, all advanced by un-paused frame ticks.
module demo_sequencer #(
    parameter int PF_W      = 7,
    parameter int NUM_PARTS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_tick,
    input  logic            pause,
    input  logic            skip,
    output logic [2:0]      part,
    output logic [PF_W-1:0] part_frame,
    output logic [2:0]      fade,
    output logic [4:0]      env,
    output logic            accent,
    output logic            beat_hit,
    output logic            part_start,
    output logic [11:0]     frame_count
);

    typedef enum logic [1:0] {FADE_IN, RUN, FADE_OUT} state_t;

    localparam int              FPP         = 1 << PF_W;
    localparam logic [PF_W-1:0] PF_FADE_OUT = PF_W'(FPP - 8);
    localparam logic [PF_W-1:0] PF_LAST     = PF_W'(FPP - 1);
    localparam logic [2:0]      PART_LAST   = 3'(NUM_PARTS - 1);

    state_t          state_q, state_d;
    logic [2:0]      part_q, part_d;
    logic [PF_W-1:0] pf_q, pf_d;
    logic [2:0]      fade_q, fade_d;
    logic [4:0]      beat_q, beat_d;
    logic            beat_hit_q, beat_hit_d;
    logic            part_start_q, part_start_d;
    logic [11:0]     fc_q, fc_d;

    logic            step;
    logic            skip_ok;
    logic [PF_W-1:0] pf_next;
    logic [4:0]      beat_next;

    // Envelope decays 31, 27, ..., 3 across each 8-frame beat.
    function automatic logic [4:0] env_of(input logic [2:0] b);
        return 5'd31 - {b, 2'b00};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FADE_IN;
            part_q       <= '0;
            pf_q         <= '0;
            fade_q       <= '0;
            beat_q       <= '0;
            beat_hit_q   <= 1'b0;
            part_start_q <= 1'b0;
            fc_q         <= '0;
        end else begin
            state_q      <= state_d;
            part_q       <= part_d;
            pf_q         <= pf_d;
            fade_q       <= fade_d;
            beat_q       <= beat_d;
            beat_hit_q   <= beat_hit_d;
            part_start_q <= part_start_d;
            fc_q         <= fc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        part_d       = part_q;
        pf_d         = pf_q;
        fade_d       = fade_q;
        beat_d       = beat_q;
        beat_hit_d   = 1'b0;
        part_start_d = 1'b0;
        fc_d         = fc_q;

        step      = frame_tick & ~pause;
        skip_ok   = skip & ~pause & (state_q != FADE_OUT);
        pf_next   = pf_q + PF_W'(1);
        beat_next = beat_q + 5'd1;

        // Skip takes priority over a coincident step: the step is dropped.
        if (skip_ok) begin
            pf_d    = PF_FADE_OUT;
            fade_d  = 3'd7;
            state_d = FADE_OUT;
        end else if (step) begin
            fc_d       = fc_q + 12'd1;
            pf_d       = pf_next;
            beat_d     = beat_next;
            beat_hit_d = (beat_next[2:0] == 3'd0);
            case (state_q)
                FADE_IN: begin
                    fade_d = fade_q + 3'd1;
                    if (fade_q == 3'd6) state_d = RUN;
                end
                RUN: begin
                    if (pf_next == PF_FADE_OUT) state_d = FADE_OUT;
                end
                FADE_OUT: begin
                    if (pf_q == PF_LAST) begin
                        part_d       = (part_q == PART_LAST) ? 3'd0 : part_q + 3'd1;
                        fade_d       = 3'd0;
                        beat_d       = 5'd0;
                        beat_hit_d   = 1'b0;
                        part_start_d = 1'b1;
                        state_d      = FADE_IN;
                    end else begin
                        fade_d = fade_q - 3'd1;
                    end
                end
                default: state_d = FADE_IN;
            endcase
        end
    end

    assign part        = part_q;
    assign part_frame  = pf_q;
    assign fade        = fade_q;
    assign env         = env_of(beat_q[2:0]);
    assign accent      = (beat_q[4:3] == 2'b10);
    assign beat_hit    = beat_hit_q;
    assign part_start  = part_start_q;
    assign frame_count = fc_q;

endmodule
